// File: rtl/fft_bin_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fft_bin_reader
//  Purpose  : Streams FFT bins from the sample RAM (port B) in natural order,
//             undoing bit-reversed storage, as alpha-max-plus-beta-min
//             magnitudes over a valid/ready interface.
//  Revision : 1.0 - initial release
// ============================================================================
module fft_bin_reader #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 13,
    parameter int N_OUT  = 64,
    parameter int BITREV = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [ADDR_W-1:0]     ram_addr,
    input  logic [2*DATA_W-1:0]   ram_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W-1:0]     out_bin,
    output logic [DATA_W-1:0]     out_mag,
    output logic                  out_last
);

    localparam logic [1:0]        c_ST_IDLE  = 2'd0;
    localparam logic [1:0]        c_ST_RUN   = 2'd1;
    localparam logic [1:0]        c_ST_DRAIN = 2'd2;
    localparam logic [ADDR_W-1:0] c_LAST_K   = ADDR_W'(N_OUT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_rd_k;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_k;
    logic [ADDR_W-1:0] r_fifo_bin [2];
    logic [DATA_W-1:0] r_fifo_mag [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              r_done;

    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic [2:0]        w_outstanding;
    logic [ADDR_W-1:0] w_head_bin;
    logic              w_head_last;
    logic [DATA_W-1:0] w_re;
    logic [DATA_W-1:0] w_im;
    logic [DATA_W-1:0] w_abs_re;
    logic [DATA_W-1:0] w_abs_im;
    logic [DATA_W-1:0] w_max;
    logic [DATA_W-1:0] w_min;
    logic [DATA_W-1:0] w_mag;

    // Bin k lives at address bitrev(k) when the FFT left its output scrambled.
    generate
        if (BITREV != 0) begin : g_bitrev
            for (genvar i = 0; i < ADDR_W; i++) begin : g_bit
                assign w_rd_addr[i] = r_rd_k[ADDR_W-1-i];
            end
        end else begin : g_natural
            assign w_rd_addr = r_rd_k;
        end
    endgenerate

    // Magnitude of the word returned by the RAM this cycle. The two's-complement
    // negate of the most negative value yields 2**(DATA_W-1), which is exactly
    // right when the result is read as unsigned.
    assign w_re     = ram_dout[DATA_W-1:0];
    assign w_im     = ram_dout[2*DATA_W-1:DATA_W];
    assign w_abs_re = w_re[DATA_W-1] ? (~w_re + DATA_W'(1)) : w_re;
    assign w_abs_im = w_im[DATA_W-1] ? (~w_im + DATA_W'(1)) : w_im;
    assign w_max    = (w_abs_re > w_abs_im) ? w_abs_re : w_abs_im;
    assign w_min    = (w_abs_re > w_abs_im) ? w_abs_im : w_abs_re;
    assign w_mag    = w_max + (w_min >> 1);

    // FIFO handshake. A pop in this cycle frees a slot in time for a read
    // issued now, which is what sustains one bin per clock with ready high.
    assign w_push        = r_inflight;
    assign w_pop         = out_valid & out_ready;
    assign w_outstanding = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_head_bin    = r_fifo_bin[r_rd_ptr];
    assign w_head_last   = (w_head_bin == c_LAST_K);

    assign busy      = (r_state != c_ST_IDLE);
    assign done      = r_done;
    assign ram_en    = w_issue;
    assign ram_addr  = w_issue ? w_rd_addr : '0;
    assign out_valid = (r_count != 2'd0);
    assign out_bin   = out_valid ? w_head_bin : '0;
    assign out_mag   = out_valid ? r_fifo_mag[r_rd_ptr] : '0;
    assign out_last  = out_valid & w_head_last;

    // Next-state and read-issue decision.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_issue = (w_outstanding < 3'd2);
                if (w_issue && (r_rd_k == c_LAST_K)) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register, read counter, in-flight tag and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_rd_k       <= '0;
            r_inflight   <= 1'b0;
            r_inflight_k <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_inflight   <= w_issue;
            r_done       <= (r_state == c_ST_DRAIN) && w_pop && w_head_last;
            if (w_issue) begin
                r_inflight_k <= r_rd_k;
            end
            if ((r_state == c_ST_IDLE) && start) begin
                r_rd_k <= '0;
            end else if (w_issue && (r_rd_k != c_LAST_K)) begin
                r_rd_k <= r_rd_k + ADDR_W'(1);
            end
        end
    end

    // Two-entry output FIFO holding converted bins tagged with their index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_bin[i] <= '0;
                r_fifo_mag[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_bin[r_wr_ptr] <= r_inflight_k;
                r_fifo_mag[r_wr_ptr] <= w_mag;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_bin_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_bin_reader
//  Purpose  : Directed self-checking bench for fft_bin_reader (bit-reversed
//             64-bin instance and natural-order 128-bin instance).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bin_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, ready_a, start_b, ready_b;
    logic        busy_a, done_a, ram_en_a, out_valid_a, out_last_a;
    logic        busy_b, done_b, ram_en_b, out_valid_b, out_last_b;
    logic [6:0]  ram_addr_a, out_bin_a, ram_addr_b, out_bin_b;
    logic [12:0] out_mag_a, out_mag_b;
    logic [25:0] dout_a, dout_b;
    logic [25:0] mem_a [128];
    logic [25:0] mem_b [128];
    int          re_a [128];
    int          im_a [128];
    int          cap_mag [128];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fft_bin_reader #(.ADDR_W(7), .DATA_W(13), .N_OUT(64), .BITREV(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .ram_en(ram_en_a), .ram_addr(ram_addr_a), .ram_dout(dout_a),
        .out_valid(out_valid_a), .out_ready(ready_a), .out_bin(out_bin_a),
        .out_mag(out_mag_a), .out_last(out_last_a)
    );

    fft_bin_reader #(.ADDR_W(7), .DATA_W(13), .N_OUT(128), .BITREV(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .ram_en(ram_en_b), .ram_addr(ram_addr_b), .ram_dout(dout_b),
        .out_valid(out_valid_b), .out_ready(ready_b), .out_bin(out_bin_b),
        .out_mag(out_mag_b), .out_last(out_last_b)
    );

    // Synchronous-read RAM models for port B of each instance.
    always @(posedge clk) begin
        if (ram_en_a) dout_a <= mem_a[ram_addr_a];
        if (ram_en_b) dout_b <= mem_b[ram_addr_b];
    end

    function automatic int bitrev7(input int k);
        int r = 0;
        for (int i = 0; i < 7; i++) r |= ((k >> i) & 1) << (6 - i);
        return r;
    endfunction

    function automatic int mag_model(input int re, input int im);
        int a = (re < 0) ? -re : re;
        int b = (im < 0) ? -im : im;
        return (a > b) ? a + b / 2 : b + a / 2;
    endfunction

    function automatic logic [25:0] mk_word(input int re, input int im);
        logic [12:0] r13, i13;
        r13 = re[12:0];
        i13 = im[12:0];
        return {i13, r13};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_a();
        for (int a = 0; a < 128; a++) mem_a[a] = mk_word(re_a[a], im_a[a]);
    endtask

    task automatic run_frame(input int stall_at, input int stall_len,
                             input int restart_at, input int abort_at,
                             input bit chk_lat);
        int k_exp = 0, words = 0, dones = 0, stall_left = 0, post = 0;
        int last_hs = -10, held_bin = 0, held_mag = 0;
        bit stalled = 0, restarted = 0, holding = 0;
        start_a = 1'b1;
        ready_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (abort_at >= 0 && out_valid_a && int'(out_bin_a) == abort_at) begin
                ready_a = 1'b0;
                rst     = 1'b1;
                tick();
                rst = 1'b0;
                #1;
                check("rst_valid", out_valid_a, 0);
                check("rst_bin", out_bin_a, 0);
                check("rst_mag", out_mag_a, 0);
                check("rst_last", out_last_a, 0);
                check("rst_ram_en", ram_en_a, 0);
                check("rst_ram_addr", ram_addr_a, 0);
                check("rst_busy", busy_a, 0);
                check("rst_done", done_a, 0);
                tick();
                check("rst_no_stale_word", out_valid_a, 0);
                ready_a = 1'b1;
                return;
            end
            ready_a = 1'b1;
            start_a = 1'b0;
            if (stall_left > 0) begin
                ready_a = 1'b0;
            end else if (!stalled && stall_at >= 0 && out_valid_a &&
                         int'(out_bin_a) == stall_at) begin
                stalled    = 1;
                stall_left = stall_len;
                ready_a    = 1'b0;
            end
            if (!restarted && restart_at >= 0 && out_valid_a &&
                int'(out_bin_a) == restart_at) begin
                restarted = 1;
                start_a   = 1'b1;
            end
            #1;
            if (chk_lat) begin
                if (cyc == 0) begin
                    check("lat_ram_en", ram_en_a, 1);
                    check("lat_ram_addr", ram_addr_a, 0);
                end
                if (cyc < 2) check("lat_valid_early", out_valid_a, 0);
                if (cyc >= 2 && cyc <= 65) check("valid_stream", out_valid_a, 1);
            end
            if (!ready_a) begin
                check("stall_ram_en", ram_en_a, 0);
                if (holding) begin
                    check("hold_valid", out_valid_a, 1);
                    check("hold_bin", out_bin_a, held_bin);
                    check("hold_mag", out_mag_a, held_mag);
                end
                holding    = 1;
                held_bin   = out_bin_a;
                held_mag   = out_mag_a;
                stall_left = stall_left - 1;
            end else begin
                holding = 0;
            end
            if (out_valid_a && ready_a) begin
                check("bin_order", out_bin_a, k_exp);
                check("bin_mag", out_mag_a, mag_model(re_a[bitrev7(k_exp)], im_a[bitrev7(k_exp)]));
                check("bin_last", out_last_a, (k_exp == 63) ? 1 : 0);
                if (k_exp < 128) cap_mag[k_exp] = out_mag_a;
                k_exp++;
                words++;
                last_hs = cyc;
            end
            if (done_a) begin
                dones++;
                check("done_timing", cyc, last_hs + 1);
            end else if (dones > 0) begin
                check("post_done_valid", out_valid_a, 0);
                check("post_done_busy", busy_a, 0);
                post++;
            end
            if (post >= 3) break;
            tick();
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        check("frame_words", words, 64);
        check("frame_dones", dones, 1);
    endtask

    task automatic run_b();
        int a_exp = 0, k = 0, dones = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (ram_en_b) begin
                check("b_ram_addr", ram_addr_b, a_exp);
                a_exp++;
            end
            if (out_valid_b) begin
                check("b_bin", out_bin_b, k);
                check("b_mag", out_mag_b, mag_model(k, -2 * k));
                check("b_last", out_last_b, (k == 127) ? 1 : 0);
                k++;
            end
            if (done_b) dones++;
            if (dones > 0) break;
            tick();
        end
        check("b_reads", a_exp, 128);
        check("b_words", k, 128);
        check("b_dones", dones, 1);
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        for (int a = 0; a < 128; a++) begin
            re_a[a]  = -a;
            im_a[a]  = a;
            mem_b[a] = mk_word(a, -2 * a);
        end
        load_a();
        repeat (3) tick();

        // Reset state of both instances.
        check("reset_valid", out_valid_a, 0);
        check("reset_bin", out_bin_a, 0);
        check("reset_mag", out_mag_a, 0);
        check("reset_last", out_last_a, 0);
        check("reset_ram_en", ram_en_a, 0);
        check("reset_ram_addr", ram_addr_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_b_valid", out_valid_b, 0);
        check("reset_b_busy", busy_b, 0);
        rst = 1'b0;
        tick();

        // Full frame with the ramp pattern; bin 1 comes from address 64.
        run_frame(-1, 0, -1, -1, 1);
        check("bin1_from_addr64", cap_mag[1], 96);

        // Directed arithmetic words placed on bins 0..4.
        re_a[0]  = 3;     im_a[0]  = -4;
        re_a[64] = -4096; im_a[64] = 0;
        re_a[32] = -4096; im_a[32] = -4096;
        re_a[96] = 0;     im_a[96] = 0;
        re_a[16] = 4095;  im_a[16] = 1;
        load_a();
        run_frame(-1, 0, -1, -1, 0);
        check("arith_3_m4", cap_mag[0], 5);
        check("arith_m4096_0", cap_mag[1], 4096);
        check("arith_m4096_m4096", cap_mag[2], 6144);
        check("arith_0_0", cap_mag[3], 0);
        check("arith_4095_1", cap_mag[4], 4095);

        // Backpressure for 6 cycles at bin 5.
        run_frame(5, 6, -1, -1, 0);

        // Start pulsed while busy at bin 20.
        run_frame(-1, 0, 20, -1, 0);

        // Reset mid-frame at bin 30, then a clean frame.
        run_frame(-1, 0, -1, 30, 0);
        tick();
        run_frame(-1, 0, -1, -1, 1);

        // Natural order, 128 bins.
        run_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
